// File: rtl/adc_capture_scheduler.sv
// Multi-frame capture sequencer for the LTC2324-16 -> AXIS DMA path (adc_clk domain).
// Starts each frame, waits for the capture block, inserts inter-frame gaps, and reports done/abort/error status.
//
//   state | meaning
//   IDLE  | waiting for cmd_start; also the landing state after an abort
//   ARM   | sample_start high, waiting for the capture block to raise st_clr
//   RUN   | frame sampling; waiting for the st_clr falling edge
//   GAP   | idle spacing between frames
//   DONE  | requested frame count reached
//   ERR   | timeout or frame_len of 0; err held until the next start
module adc_capture_scheduler #(
    parameter int CNT_W = 32,
    parameter int FRM_W = 16
) (
    input  logic             adc_clk,
    input  logic             adc_rst_n,
    input  logic [CNT_W-1:0] cfg_frame_len,
    input  logic [FRM_W-1:0] cfg_frame_num,
    input  logic [CNT_W-1:0] cfg_interval,
    input  logic [CNT_W-1:0] cfg_timeout,
    input  logic             cmd_start,
    input  logic             cmd_abort,
    input  logic             st_clr,
    output logic [CNT_W-1:0] sample_len,
    output logic             sample_start,
    output logic             adc_en,
    output logic             busy,
    output logic [FRM_W-1:0] frame_cnt,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        RUN  = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] lat_len, lat_int, lat_to;
    logic [FRM_W-1:0] lat_num, frame_inc;
    logic [CNT_W-1:0] to_cnt, gap_cnt;
    logic             st_clr_q, fall, start_ok, timeout;

    always_comb begin
        start_ok  = cmd_start && !cmd_abort &&
                    (state == IDLE || state == DONE || state == ERR);
        fall      = st_clr_q && !st_clr;
        // to_cnt is a down-counter loaded on phase entry; terminal count is 1
        timeout   = (lat_to != '0) && (to_cnt == CNT_W'(1));
        frame_inc = (&frame_cnt) ? frame_cnt : frame_cnt + FRM_W'(1);
        state_nx  = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start_ok) state_nx = (cfg_frame_len == '0) ? ERR : ARM;
            end
            ARM: begin
                if (cmd_abort)    state_nx = IDLE;
                else if (st_clr)  state_nx = RUN;
                else if (timeout) state_nx = ERR;
            end
            RUN: begin
                if (cmd_abort) state_nx = IDLE;
                else if (fall)
                    state_nx = (lat_num != '0 && frame_inc == lat_num) ? DONE : GAP;
                else if (timeout) state_nx = ERR;
            end
            GAP: begin
                if (cmd_abort)                 state_nx = IDLE;
                else if (gap_cnt <= CNT_W'(1)) state_nx = ARM;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign sample_start = (state == ARM);
    assign busy         = (state == ARM) || (state == RUN) || (state == GAP);
    assign adc_en       = busy;
    assign sample_len   = lat_len;

    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            state     <= IDLE;
            st_clr_q  <= 1'b0;
            lat_len   <= '0;
            lat_num   <= '0;
            lat_int   <= '0;
            lat_to    <= '0;
            to_cnt    <= '0;
            gap_cnt   <= '0;
            frame_cnt <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            state    <= state_nx;
            st_clr_q <= st_clr;
            done     <= (state_nx == DONE) && (state != DONE);

            if (state_nx != state) to_cnt <= start_ok ? cfg_timeout : lat_to;
            else if (to_cnt != '0) to_cnt <= to_cnt - CNT_W'(1);

            if (state_nx == GAP && state != GAP)
                gap_cnt <= (lat_int == '0) ? CNT_W'(1) : lat_int;
            else if (gap_cnt != '0)
                gap_cnt <= gap_cnt - CNT_W'(1);

            if (start_ok) begin
                lat_len   <= cfg_frame_len;
                lat_num   <= cfg_frame_num;
                lat_int   <= cfg_interval;
                lat_to    <= cfg_timeout;
                frame_cnt <= '0;
                err       <= (cfg_frame_len == '0);
                err_code  <= (cfg_frame_len == '0) ? 2'd3 : 2'd0;
            end else begin
                if (state_nx == ERR && state != ERR) begin
                    err      <= 1'b1;
                    err_code <= (state == ARM) ? 2'd1 : 2'd2;
                end
                if (state == RUN && (state_nx == GAP || state_nx == DONE))
                    frame_cnt <= frame_inc;
            end
        end
    end

endmodule
